// File: rtl/alu_result_queue.sv
// ALU execution stage with an in-order result queue feeding the CDB.
// Computes the RV32I integer/branch result of one issued instruction per
// cycle and buffers {dest, result, jump, target} until the arbiter grants it.
module alu_result_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_rdy,
    input  logic              in_rollback,
    input  logic              in_enable,
    input  logic [OP_W-1:0]   in_type,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic [ROB_W-1:0]  in_dest,
    output logic              out_capacity_full,
    output logic              out_cdb_valid,
    input  logic              in_cdb_grant,
    output logic [ROB_W-1:0]  out_cdb_reorder,
    output logic [DATA_W-1:0] out_cdb_result,
    output logic              out_cdb_jump,
    output logic [ADDR_W-1:0] out_cdb_target,
    output logic              out_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Operator codes shared with the decoder
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(19);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(21);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(28);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(29);

    logic [DATA_W-1:0] opnd_b;
    logic [4:0]        shamt;
    logic              lt_s;
    logic              lt_u;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_plus_imm;
    logic              is_branch;
    logic [DATA_W-1:0] calc_result;
    logic              calc_jump;
    logic [ADDR_W-1:0] calc_target;

    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              do_push;
    logic              do_pop;
    logic              do_write;
    logic              drop;

    logic [ROB_W-1:0]  q_dest   [DEPTH];
    logic [DATA_W-1:0] q_result [DEPTH];
    logic              q_jump   [DEPTH];
    logic [ADDR_W-1:0] q_target [DEPTH];

    // Combinational execute: operand select, ALU, branch resolution
    always_comb begin
        opnd_b = in_right;
        if (in_type inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
                            OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU})
            opnd_b = in_imm;
        shamt       = opnd_b[4:0];
        lt_s        = $signed(in_left) < $signed(opnd_b);
        lt_u        = in_left < opnd_b;
        pc_plus4    = in_pc + ADDR_W'(4);
        pc_plus_imm = in_pc + ADDR_W'(in_imm);
        is_branch   = 1'b0;
        calc_result = '0;
        calc_jump   = 1'b0;
        calc_target = pc_plus4;
        case (in_type)
            OP_ADD, OP_ADDI:   calc_result = in_left + opnd_b;
            OP_SUB:            calc_result = in_left - opnd_b;
            OP_AND, OP_ANDI:   calc_result = in_left & opnd_b;
            OP_OR, OP_ORI:     calc_result = in_left | opnd_b;
            OP_XOR, OP_XORI:   calc_result = in_left ^ opnd_b;
            OP_SLL, OP_SLLI:   calc_result = in_left << shamt;
            OP_SRL, OP_SRLI:   calc_result = in_left >> shamt;
            OP_SRA, OP_SRAI:   calc_result = DATA_W'($signed(in_left) >>> shamt);
            OP_SLT, OP_SLTI:   calc_result = DATA_W'(lt_s);
            OP_SLTU, OP_SLTIU: calc_result = DATA_W'(lt_u);
            OP_LUI:            calc_result = in_imm;
            OP_AUIPC:          calc_result = DATA_W'(pc_plus_imm);
            OP_JAL: begin
                calc_result = DATA_W'(pc_plus4);
                calc_jump   = 1'b1;
                calc_target = pc_plus_imm;
            end
            OP_JALR: begin
                calc_result = DATA_W'(pc_plus4);
                calc_jump   = 1'b1;
                calc_target = ADDR_W'(in_left + in_imm) & ~ADDR_W'(1);
            end
            OP_BEQ:  begin is_branch = 1'b1; calc_jump = (in_left == in_right); end
            OP_BNE:  begin is_branch = 1'b1; calc_jump = (in_left != in_right); end
            OP_BLT:  begin is_branch = 1'b1; calc_jump = lt_s;  end
            OP_BGE:  begin is_branch = 1'b1; calc_jump = !lt_s; end
            OP_BLTU: begin is_branch = 1'b1; calc_jump = lt_u;  end
            OP_BGEU: begin is_branch = 1'b1; calc_jump = !lt_u; end
            default: ;
        endcase
        if (is_branch && calc_jump)
            calc_target = pc_plus_imm;
    end

    // Queue handshake decode; a pop at full frees the slot for the same-edge push
    always_comb begin
        do_push  = in_rdy && !in_rollback && in_enable;
        do_pop   = in_rdy && !in_rollback && in_cdb_grant && (count_q != '0);
        do_write = do_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        drop     = do_push && !do_write;
    end

    // Pointer, occupancy and sticky overflow registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (in_rdy && in_rollback) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_write) tail_q <= tail_q + PTR_W'(1);
            if (do_pop)   head_q <= head_q + PTR_W'(1);
            if (do_write && !do_pop)
                count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_write)
                count_q <= count_q - CNT_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Entry storage; contents only matter while counted, so no reset
    always_ff @(posedge in_clk) begin
        if (do_write) begin
            q_dest[tail_q]   <= in_dest;
            q_result[tail_q] <= calc_result;
            q_jump[tail_q]   <= calc_jump;
            q_target[tail_q] <= calc_target;
        end
    end

    assign out_cdb_valid     = (count_q != '0);
    assign out_capacity_full = (count_q >= CNT_W'(DEPTH - 1));
    assign out_overflow      = overflow_q;
    assign out_cdb_reorder   = out_cdb_valid ? q_dest[head_q]   : '0;
    assign out_cdb_result    = out_cdb_valid ? q_result[head_q] : '0;
    assign out_cdb_jump      = out_cdb_valid ? q_jump[head_q]   : 1'b0;
    assign out_cdb_target    = out_cdb_valid ? q_target[head_q] : '0;

endmodule

// File: tb/tb_alu_result_queue.sv
// Testbench for alu_result_queue: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_alu_result_queue;
    localparam int DEPTH = 4;

    localparam logic [5:0] OP_ADD = 1,  OP_SUB = 2,  OP_AND = 3,  OP_OR = 4;
    localparam logic [5:0] OP_XOR = 5,  OP_SLL = 6,  OP_SRL = 7,  OP_SRA = 8;
    localparam logic [5:0] OP_SLT = 9,  OP_SLTU = 10, OP_ADDI = 11, OP_ANDI = 12;
    localparam logic [5:0] OP_ORI = 13, OP_XORI = 14, OP_SLLI = 15, OP_SRLI = 16;
    localparam logic [5:0] OP_SRAI = 17, OP_SLTI = 18, OP_SLTIU = 19, OP_LUI = 20;
    localparam logic [5:0] OP_AUIPC = 21, OP_JAL = 22, OP_JALR = 23, OP_BEQ = 24;
    localparam logic [5:0] OP_BNE = 25, OP_BLT = 26, OP_BGE = 27, OP_BLTU = 28;
    localparam logic [5:0] OP_BGEU = 29;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_rdy;
    logic        in_rollback;
    logic        in_enable;
    logic [5:0]  in_type;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [3:0]  in_dest;
    logic        in_cdb_grant;
    logic        out_capacity_full;
    logic        out_cdb_valid;
    logic [3:0]  out_cdb_reorder;
    logic [31:0] out_cdb_result;
    logic        out_cdb_jump;
    logic [31:0] out_cdb_target;
    logic        out_overflow;

    alu_result_queue #(.DEPTH(DEPTH), .DATA_W(32), .ROB_W(4), .OP_W(6), .ADDR_W(32)) dut (
        .in_clk            (in_clk),
        .in_rst_n          (in_rst_n),
        .in_rdy            (in_rdy),
        .in_rollback       (in_rollback),
        .in_enable         (in_enable),
        .in_type           (in_type),
        .in_pc             (in_pc),
        .in_imm            (in_imm),
        .in_left           (in_left),
        .in_right          (in_right),
        .in_dest           (in_dest),
        .out_capacity_full (out_capacity_full),
        .out_cdb_valid     (out_cdb_valid),
        .in_cdb_grant      (in_cdb_grant),
        .out_cdb_reorder   (out_cdb_reorder),
        .out_cdb_result    (out_cdb_result),
        .out_cdb_jump      (out_cdb_jump),
        .out_cdb_target    (out_cdb_target),
        .out_overflow      (out_overflow)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] result;
        logic        jump;
        logic [31:0] target;
    } entry_t;

    entry_t ref_q[$];
    bit     ref_ovf;
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_compute(input logic [5:0] op, input logic [31:0] pc,
                                        input logic [31:0] imm, input logic [31:0] a,
                                        input logic [31:0] r, output logic [31:0] res,
                                        output logic j, output logic [31:0] tgt);
        res = 0;
        j   = 0;
        tgt = pc + 4;
        case (op)
            OP_ADD:   res = a + r;
            OP_ADDI:  res = a + imm;
            OP_SUB:   res = a - r;
            OP_AND:   res = a & r;
            OP_ANDI:  res = a & imm;
            OP_OR:    res = a | r;
            OP_ORI:   res = a | imm;
            OP_XOR:   res = a ^ r;
            OP_XORI:  res = a ^ imm;
            OP_SLL:   res = a << r[4:0];
            OP_SLLI:  res = a << imm[4:0];
            OP_SRL:   res = a >> r[4:0];
            OP_SRLI:  res = a >> imm[4:0];
            OP_SRA:   res = $signed(a) >>> r[4:0];
            OP_SRAI:  res = $signed(a) >>> imm[4:0];
            OP_SLT:   res = ($signed(a) < $signed(r)) ? 1 : 0;
            OP_SLTI:  res = ($signed(a) < $signed(imm)) ? 1 : 0;
            OP_SLTU:  res = (a < r) ? 1 : 0;
            OP_SLTIU: res = (a < imm) ? 1 : 0;
            OP_LUI:   res = imm;
            OP_AUIPC: res = pc + imm;
            OP_JAL:   begin res = pc + 4; j = 1; tgt = pc + imm; end
            OP_JALR:  begin res = pc + 4; j = 1; tgt = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  j = (a == r);
                    OP_BNE:  j = (a != r);
                    OP_BLT:  j = ($signed(a) < $signed(r));
                    OP_BGE:  j = ($signed(a) >= $signed(r));
                    OP_BLTU: j = (a < r);
                    default: j = (a >= r);
                endcase
                tgt = j ? pc + imm : pc + 4;
            end
            default: ;
        endcase
    endfunction

    task automatic model_edge();
        entry_t e;
        if (!in_rdy) return;
        if (in_rollback) begin
            ref_q.delete();
            return;
        end
        ref_compute(in_type, in_pc, in_imm, in_left, in_right, e.result, e.jump, e.target);
        e.dest = in_dest;
        if (in_cdb_grant && ref_q.size() > 0)
            ref_q.delete(0);
        if (in_enable) begin
            if (ref_q.size() < DEPTH) ref_q.push_back(e);
            else ref_ovf = 1;
        end
    endtask

    task automatic check_all(input string name);
        entry_t h;
        h.dest = 0; h.result = 0; h.jump = 0; h.target = 0;
        if (ref_q.size() > 0) h = ref_q[0];
        chk({name, ".valid"},  32'(out_cdb_valid),     32'(ref_q.size() != 0));
        chk({name, ".full"},   32'(out_capacity_full), 32'(ref_q.size() >= DEPTH - 1));
        chk({name, ".ovf"},    32'(out_overflow),      32'(ref_ovf));
        chk({name, ".dest"},   32'(out_cdb_reorder),   32'(h.dest));
        chk({name, ".result"}, out_cdb_result,         h.result);
        chk({name, ".jump"},   32'(out_cdb_jump),      32'(h.jump));
        chk({name, ".target"}, out_cdb_target,         h.target);
    endtask

    task automatic tick(input string name);
        @(posedge in_clk);
        model_edge();
        #1;
        check_all(name);
    endtask

    task automatic ctl(input logic rdy, input logic rb, input logic en, input logic gnt);
        in_rdy = rdy; in_rollback = rb; in_enable = en; in_cdb_grant = gnt;
    endtask

    task automatic set_op(input logic [5:0] t, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] l, input logic [31:0] r, input logic [3:0] d);
        in_type = t; in_pc = pc; in_imm = imm; in_left = l; in_right = r; in_dest = d;
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        ctl(1, 0, 0, 0);
        #2;
        ref_q.delete();
        ref_ovf = 0;
        check_all("reset");
        #2;
        in_rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return $urandom;
            2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'h8000_0000 ^ 32'($urandom_range(0, 7));
        endcase
    endfunction

    logic [5:0] op_list [31] = '{6'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
        OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
        OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ,
        OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, 6'd63};

    initial begin
        set_op(0, 0, 0, 0, 0, 0);
        ctl(1, 0, 0, 0);
        do_reset();

        // Single ADDI, held until granted
        set_op(OP_ADDI, 32'h0, 32'hFFFF_FFFD, 32'd5, 32'd0, 4'd2);
        ctl(1, 0, 1, 0);
        tick("addi");
        chk("addi_result", out_cdb_result, 32'd2);
        chk("addi_dest", 32'(out_cdb_reorder), 32'd2);
        ctl(1, 0, 0, 0);
        repeat (2) tick("addi_hold");
        chk("addi_held", out_cdb_result, 32'd2);
        ctl(1, 0, 0, 1);
        tick("addi_pop");
        chk("addi_popped_valid", 32'(out_cdb_valid), 32'd0);

        // Branch and jump results
        ctl(1, 0, 1, 0);
        set_op(OP_BLT,  32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'd1); tick("blt");
        set_op(OP_BGEU, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 4'd2); tick("bgeu");
        set_op(OP_JALR, 32'h40,  32'd2,  32'h1003,      32'd0, 4'd3); tick("jalr");
        chk("blt_jump", 32'(out_cdb_jump), 32'd1);
        chk("blt_target", out_cdb_target, 32'h120);
        ctl(1, 0, 0, 1);
        tick("pop_blt");
        chk("bgeu_jump", 32'(out_cdb_jump), 32'd1);
        chk("bgeu_target", out_cdb_target, 32'h120);
        tick("pop_bgeu");
        chk("jalr_result", out_cdb_result, 32'h44);
        chk("jalr_target", out_cdb_target, 32'h1004);
        tick("pop_jalr");

        // Fill to capacity, then drain in order
        ctl(1, 0, 1, 0);
        for (int d = 1; d <= 4; d++) begin
            set_op(OP_ADD, 32'h200, 32'd0, 32'(d * 10), 32'd1, 4'(d));
            tick("fill");
            if (d == 3) chk("full_at3", 32'(out_capacity_full), 32'd1);
        end
        chk("no_ovf_at4", 32'(out_overflow), 32'd0);
        ctl(1, 0, 0, 1);
        for (int d = 1; d <= 4; d++) begin
            chk("drain_order", 32'(out_cdb_reorder), 32'(d));
            tick("drain");
        end

        // Push+pop at full, then a dropped push
        ctl(1, 0, 1, 0);
        for (int d = 1; d <= 4; d++) begin
            set_op(OP_XORI, 32'h300, 32'h55, 32'(d), 32'd0, 4'(d));
            tick("refill");
        end
        set_op(OP_ORI, 32'h300, 32'hF0, 32'd5, 32'd0, 4'd5);
        ctl(1, 0, 1, 1);
        tick("push_pop_full");
        chk("pp_no_ovf", 32'(out_overflow), 32'd0);
        chk("pp_head", 32'(out_cdb_reorder), 32'd2);
        set_op(OP_ORI, 32'h300, 32'hF0, 32'd6, 32'd0, 4'd6);
        ctl(1, 0, 1, 0);
        tick("drop");
        chk("drop_ovf", 32'(out_overflow), 32'd1);
        ctl(1, 0, 0, 0);
        repeat (2) tick("ovf_hold");
        chk("ovf_sticky", 32'(out_overflow), 32'd1);
        do_reset();

        // Rollback with simultaneous push and grant
        ctl(1, 0, 1, 0);
        set_op(OP_SUB, 32'h400, 32'd0, 32'd9, 32'd4, 4'd7); tick("rb_pre1");
        set_op(OP_SUB, 32'h404, 32'd0, 32'd8, 32'd4, 4'd8); tick("rb_pre2");
        ctl(1, 1, 1, 1);
        tick("rollback");
        chk("rb_valid", 32'(out_cdb_valid), 32'd0);
        ctl(1, 0, 1, 0);
        set_op(OP_LUI, 32'h408, 32'hABCD_E000, 32'd0, 32'd0, 4'd9);
        tick("rb_after");
        chk("rb_new_head", 32'(out_cdb_reorder), 32'd9);
        chk("rb_new_full", 32'(out_capacity_full), 32'd0);

        // Frozen by in_rdy=0, then asynchronous reset mid-cycle
        ctl(0, 0, 1, 1);
        repeat (3) tick("frozen");
        chk("frozen_head", 32'(out_cdb_reorder), 32'd9);
        #3;
        in_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_cdb_valid), 32'd0);
        ref_q.delete();
        ref_ovf = 0;
        check_all("async_rst");
        #1;
        in_rst_n = 1'b1;
        ctl(1, 0, 0, 0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if (c % 200 == 199) do_reset();
            ctl(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1));
            set_op(op_list[$urandom_range(0, 30)], $urandom & 32'hFFFF_FFFC, rnd_val(),
                   rnd_val(), rnd_val(), 4'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
